// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode and FSM state encodings for universal_shift_register
package usr_pkg;

  // Parallel operations selected by Mode while idle
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ASR  = 3'b101,
    MODE_REV  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  // Serial transfer sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - step counter with synchronous clear and terminal-count flag
module bit_counter #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] LAST  = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_terminal
);

  logic [WIDTH-1:0] r_count;

  // Clear wins over increment; saturating at LAST keeps the count inside 0..LAST
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_terminal = (r_count == LAST);

endmodule

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - universal shift register with N-bit serial transfer sequencer
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Enable,
  input  logic         Load,
  input  logic [2:0]   Mode,
  input  logic [N-1:0] Input,
  input  logic         LeftInput,
  input  logic         RightInput,
  input  logic         Start,
  output logic [N-1:0] Q,
  output logic         SerialOut,
  output logic         Busy,
  output logic         Done
);

  localparam int CNT_W = $clog2(N);

  state_e         r_state;
  state_e         w_state_next;
  logic [N-1:0]   r_q;
  logic [N-1:0]   w_q_next;
  logic [N-1:0]   w_step;
  logic [N-1:0]   w_rev;
  logic           w_term;
  logic           w_clear;
  logic           w_inc;

  // Counter only runs in SHIFT; it is zeroed everywhere else and on the final step
  assign w_inc   = (r_state == ST_SHIFT);
  assign w_clear = Load || (r_state != ST_SHIFT) || w_term;

  bit_counter #(
    .WIDTH (CNT_W),
    .LAST  (CNT_W'(N - 1))
  ) u_bit_counter (
    .clk        (Clock),
    .reset      (Reset),
    .i_clear    (w_clear),
    .i_inc      (w_inc),
    .o_terminal (w_term)
  );

  // One serial transfer step: outgoing bit leaves at the SerialOut end
  assign w_step = MSB_FIRST ? {r_q[N-2:0], RightInput} : {LeftInput, r_q[N-1:1]};

  // Bit-reversed copy of the register for MODE_REV
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < N; i++) begin
      w_rev[N-1-i] = r_q[i];
    end
  end

  // FSM state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: Load aborts anything, Start only launches from IDLE
  always_comb begin
    w_state_next = r_state;
    if (Load) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_next = Start ? ST_SHIFT : ST_IDLE;
        ST_SHIFT: w_state_next = w_term ? ST_DONE : ST_SHIFT;
        ST_DONE:  w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    Busy = (r_state == ST_SHIFT);
    Done = (r_state == ST_DONE);
  end

  // Datapath next value: Load > Start (holds Q) > transfer step > Enable/Mode > hold
  always_comb begin
    w_q_next = r_q;
    if (Load) begin
      w_q_next = Input;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!Start && Enable) begin
            case (mode_e'(Mode))
              MODE_SHL: w_q_next = {r_q[N-2:0], RightInput};
              MODE_SHR: w_q_next = {LeftInput, r_q[N-1:1]};
              MODE_ROL: w_q_next = {r_q[N-2:0], r_q[N-1]};
              MODE_ROR: w_q_next = {r_q[0], r_q[N-1:1]};
              MODE_ASR: w_q_next = {r_q[N-1], r_q[N-1:1]};
              MODE_REV: w_q_next = w_rev;
              default:  w_q_next = r_q;
            endcase
          end
        end
        ST_SHIFT: w_q_next = w_step;
        default:  w_q_next = r_q;
      endcase
    end
  end

  // Register contents
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign Q         = r_q;
  assign SerialOut = MSB_FIRST ? r_q[N-1] : r_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - scoreboard bench for universal_shift_register (MSB and LSB first)
module tb_universal_shift_register;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ld = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] din = 8'h00;
  logic       lin = 1'b0;
  logic       rin = 1'b0;
  logic       st = 1'b0;

  logic [7:0] q0, q1;
  logic       so0, so1, busy0, busy1, done0, done1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  universal_shift_register #(.N(8), .MSB_FIRST(1'b1)) u_dut_msb (
    .Clock(clk), .Reset(rst), .Enable(en), .Load(ld), .Mode(mode), .Input(din),
    .LeftInput(lin), .RightInput(rin), .Start(st),
    .Q(q0), .SerialOut(so0), .Busy(busy0), .Done(done0)
  );

  universal_shift_register #(.N(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .Clock(clk), .Reset(rst), .Enable(en), .Load(ld), .Mode(mode), .Input(din),
    .LeftInput(lin), .RightInput(rin), .Start(st),
    .Q(q1), .SerialOut(so1), .Busy(busy1), .Done(done1)
  );

  typedef struct packed {
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       so;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // Behavioural model: register value, steps still to go, done flag
  logic [7:0] m_q[2] = '{8'h00, 8'h00};
  int         m_left[2] = '{0, 0};
  bit         m_done[2] = '{1'b0, 1'b0};

  function automatic logic [7:0] reverse8(input logic [7:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < 8; b++) r[7 - b] = v[b];
    return r;
  endfunction

  task automatic model_update(input int k);
    bit msb;
    msb = (k == 0);
    if (rst) begin
      m_q[k] = 8'h00; m_left[k] = 0; m_done[k] = 1'b0;
    end else if (ld) begin
      m_q[k] = din; m_left[k] = 0; m_done[k] = 1'b0;
    end else if (m_left[k] > 0) begin
      if (msb) m_q[k] = (m_q[k] << 1) | {7'd0, rin};
      else     m_q[k] = (m_q[k] >> 1) | {lin, 7'd0};
      m_left[k] = m_left[k] - 1;
      m_done[k] = (m_left[k] == 0);
    end else if (m_done[k]) begin
      m_done[k] = 1'b0;
    end else begin
      if (st) begin
        m_left[k] = 8;
      end else if (en) begin
        case (mode)
          3'd1: m_q[k] = (m_q[k] << 1) | {7'd0, rin};
          3'd2: m_q[k] = (m_q[k] >> 1) | {lin, 7'd0};
          3'd3: m_q[k] = (m_q[k] << 1) | (m_q[k] >> 7);
          3'd4: m_q[k] = (m_q[k] >> 1) | (m_q[k] << 7);
          3'd5: m_q[k] = (m_q[k] >> 1) | (m_q[k] & 8'h80);
          3'd6: m_q[k] = reverse8(m_q[k]);
          default: ;
        endcase
      end
    end
  endtask

  function automatic exp_t model_out(input int k);
    exp_t e;
    e.q    = m_q[k];
    e.busy = (m_left[k] > 0);
    e.done = m_done[k];
    e.so   = (k == 0) ? m_q[k][7] : m_q[k][0];
    return e;
  endfunction

  // Apply current inputs for one edge: update model, queue expectations, advance
  task automatic cycle();
    model_update(0);
    model_update(1);
    exp_q0.push_back(model_out(0));
    exp_q1.push_back(model_out(1));
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: compare every post-edge output against the queued expectation
  exp_t e0, e1;
  always @(posedge clk) begin
    #1;
    if (exp_q0.size() > 0) begin
      e0 = exp_q0.pop_front();
      total++;
      if ({q0, busy0, done0, so0} !== e0) begin
        bad++;
        $display("FAIL sb_msb act q=%h b=%b d=%b so=%b exp q=%h b=%b d=%b so=%b",
                 q0, busy0, done0, so0, e0.q, e0.busy, e0.done, e0.so);
      end
    end
    if (exp_q1.size() > 0) begin
      e1 = exp_q1.pop_front();
      total++;
      if ({q1, busy1, done1, so1} !== e1) begin
        bad++;
        $display("FAIL sb_lsb act q=%h b=%b d=%b so=%b exp q=%h b=%b d=%b so=%b",
                 q1, busy1, done1, so1, e1.q, e1.busy, e1.done, e1.so);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  mode_e      sweep_mode[7] = '{MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_REV, MODE_HOLD};
  logic [7:0] sweep_res[7]  = '{8'h2D, 8'h4B, 8'h2D, 8'h4B, 8'hCB, 8'h69, 8'h96};
  logic       msb_bits[8]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       fill_bits[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #2;
    rst = 1'b1; cycle();
    rst = 1'b0;
    chk("reset_q", q0, 8'h00);
    chk("reset_busy_done", {6'd0, busy0, done0}, 8'h00);

    // Mode sweep from fresh load of 1001_0110
    for (int i = 0; i < 7; i++) begin
      ld = 1'b1; din = 8'h96; cycle();
      ld = 1'b0; en = 1'b1; mode = sweep_mode[i]; rin = 1'b1; lin = 1'b0; cycle();
      en = 1'b0;
      chk($sformatf("sweep_msb_mode%0d", sweep_mode[i]), q0, sweep_res[i]);
      chk($sformatf("sweep_lsb_mode%0d", sweep_mode[i]), q1, sweep_res[i]);
    end
    mode = 3'b000;

    // MSB-first transfer of C3 with zero fill
    ld = 1'b1; din = 8'hC3; cycle();
    ld = 1'b0; st = 1'b1; rin = 1'b0; lin = 1'b0; cycle();
    st = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("msb_so_%0d", i), {6'd0, busy0, so0}, {6'd0, 1'b1, msb_bits[i]});
      cycle();
    end
    chk("msb_done_pulse", {7'd0, done0}, 8'h01);
    chk("msb_final_q", q0, 8'h00);
    cycle();
    chk("msb_done_gone", {6'd0, busy0, done0}, 8'h00);

    // LSB-first full-duplex transfer of 01
    ld = 1'b1; din = 8'h01; cycle();
    ld = 1'b0; st = 1'b1; cycle();
    st = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lin = fill_bits[i];
      chk($sformatf("lsb_so_%0d", i), {7'd0, so1}, {7'd0, (i == 0)});
      cycle();
    end
    chk("lsb_final_q", q1, 8'h4D);
    chk("lsb_done_pulse", {7'd0, done1}, 8'h01);
    cycle();

    // Reset in the middle of a transfer
    ld = 1'b1; din = 8'hA5; cycle();
    ld = 1'b0; st = 1'b1; cycle();
    st = 1'b0;
    repeat (3) cycle();
    rst = 1'b1; cycle();
    rst = 1'b0;
    chk("midreset_q", q0, 8'h00);
    chk("midreset_busy_done", {6'd0, busy0, done0}, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("midreset_no_done", {7'd0, done0}, 8'h00);
    end

    // Load aborts a transfer at step 4
    ld = 1'b1; din = 8'hA5; cycle();
    ld = 1'b0; st = 1'b1; cycle();
    st = 1'b0;
    repeat (4) cycle();
    ld = 1'b1; din = 8'h3C; cycle();
    ld = 1'b0;
    chk("abort_q", q0, 8'h3C);
    chk("abort_busy", {7'd0, busy0}, 8'h00);
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("abort_no_done", {7'd0, done0}, 8'h00);
    end

    // Load and Start together: load only
    ld = 1'b1; st = 1'b1; din = 8'h55; cycle();
    ld = 1'b0; st = 1'b0;
    chk("ldst_q", q0, 8'h55);
    chk("ldst_busy", {7'd0, busy0}, 8'h00);

    // Start and Mode ignored while Busy
    ld = 1'b1; din = 8'h96; cycle();
    ld = 1'b0; st = 1'b1; rin = 1'b0; cycle();
    en = 1'b1; mode = 3'b001;
    repeat (8) cycle();
    chk("busy_ignore_done", {7'd0, done0}, 8'h01);
    chk("busy_ignore_q", q0, 8'h00);
    st = 1'b0; en = 1'b0; mode = 3'b000; cycle();

    // Randomized traffic, checked by the scoreboard
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom_range(0, 99) < 2);
      ld   = ($urandom_range(0, 99) < 5);
      st   = ($urandom_range(0, 99) < 15);
      en   = $urandom_range(0, 1);
      mode = 3'($urandom_range(0, 7));
      din  = 8'($urandom);
      lin  = $urandom_range(0, 1);
      rin  = $urandom_range(0, 1);
      cycle();
    end
    rst = 1'b0; ld = 1'b0; st = 1'b0; en = 1'b0;

    repeat (3) @(posedge clk);
    #3;
    total++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      bad++;
      $display("FAIL drain act=%0d exp=0", exp_q0.size() + exp_q1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 The block SHALL have parameter N, default 8, register width (N >= 2).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: serial transfer bit order (1 = MSB first, 0 = LSB first).
REQ-003 The block SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port Enable  input  1  qualifies the Mode operation when idle.
REQ-006 The block SHALL have port Load  input  1  parallel load of Input.
REQ-007 The block SHALL have port Mode  input  3  operation select (encodings per REQ-013).
REQ-008 The block SHALL have port Input  input  N  parallel load data.
REQ-009 The block SHALL have port LeftInput  input  1  serial fill bit entering at Q[N-1].
REQ-010 The block SHALL have port RightInput  input  1  serial fill bit entering at Q[0].
REQ-011 The block SHALL have port Start  input  1  starts an N-bit serial transfer.
REQ-012 The block SHALL have outputs:
- Q, N bits: register contents.
- SerialOut, 1 bit: current transfer bit.
- Busy, 1 bit: transfer in progress.
- Done, 1 bit: one-cycle transfer-complete pulse.

Function
REQ-013 Mode encodings SHALL be:
- 000 hold.
- 001 shift left: {Q[N-2:0],RightInput}.
- 010 shift right: {LeftInput,Q[N-1:1]}.
- 011 rotate left.
- 100 rotate right.
- 101 arithmetic shift right: {Q[N-1],Q[N-1:1]}.
- 110 bit reverse.
- 111 hold (reserved).
REQ-014 Per-edge priority SHALL be: Reset > Load > Start (IDLE only) > transfer step (SHIFT only) > Enable/Mode (IDLE only) > hold.
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE; Busy = (state == SHIFT) and Done = (state == DONE).
REQ-016 In IDLE, Start=1 and Load=0 SHALL go to SHIFT with counter 0 and leave Q unchanged on that edge.
REQ-017 Each SHIFT-state edge SHALL perform one transfer step and increment the counter:
- MSB_FIRST=1: shift left, filling from RightInput.
- MSB_FIRST=0: shift right, filling from LeftInput.
REQ-018 The edge with counter == N-1 in SHIFT SHALL perform the final step and go to DONE, giving exactly N steps with Busy high for N cycles.
REQ-019 DONE SHALL last exactly one cycle, then go to IDLE unconditionally; Start and Enable SHALL be ignored in DONE and Q held (Load still honoured).
REQ-020 SerialOut SHALL be combinational: Q[N-1] if MSB_FIRST else Q[0], in all states.
REQ-021 Start, Enable and Mode SHALL be ignored while Busy.
REQ-022 Load while Busy SHALL abort: Q <= Input, state IDLE, counter 0, and no Done pulse.
REQ-023 Load and Start asserted on the same IDLE edge SHALL perform only the load, with no transfer started.
REQ-024 The counter SHALL be clog2(N) bits wide, never exceed N-1, and hold 0 outside SHIFT.

Reset
REQ-025 Reset=1 at a rising edge SHALL set Q=0, state IDLE, counter 0, Busy=0, Done=0, overriding all other inputs, including mid-transfer.
REQ-026 Reset SHALL have no asynchronous effect; outputs change only at Clock edges.

Structure
REQ-027 Mode encodings and FSM state encodings SHALL be defined as constants in shared package usr_pkg, which the RTL and the bench both use.
REQ-028 The transfer counter SHALL be the sub-module bit_counter (parameter WIDTH, with clear, increment and terminal-count-at-N-1 outputs); all other logic SHALL stay in universal_shift_register.

Verification (N=8)
REQ-029 Reset mid-transfer: load 8'hA5, Start, Reset at step 3 -> next cycle Q=8'h00, Busy=0, Done=0; no Done pulse afterward.
REQ-030 Mode sweep: Q=8'b1001_0110, Enable=1, apply each Mode for one cycle from a fresh load -> expected results:
- 001, RightInput=1: 8'b0010_1101.
- 010, LeftInput=0: 8'b0100_1011.
- 011: 8'b0010_1101.
- 100: 8'b0100_1011.
- 101: 8'b1100_1011.
- 110: 8'b0110_1001.
- 000: unchanged.
REQ-031 Transfer MSB_FIRST=1: load 8'hC3, Start, RightInput held 0 -> SerialOut sequence 1,1,0,0,0,0,1,1 over 8 Busy cycles; Done high on cycle 9 only; final Q=8'h00.
REQ-032 Full-duplex transfer, MSB_FIRST=0: load 8'h01, Start, LeftInput driven 1,0,1,1,0,0,1,0 -> SerialOut 1 then 0s; final Q=8'h4D.
REQ-033 Abort and priority:
- Load 8'h3C at step 4 of a transfer -> Q=8'h3C, Busy=0, no Done.
- Load and Start on the same edge -> load only, Busy stays 0.
- Start and Mode=001 during Busy -> ignored.
